// File: rtl/fft_frame_sched.sv
// Arbitrates TX (IFFT) and RX (FFT) requesters onto the shared FFT core one whole frame at a time
// and tags each frame leaving the core with its owner via a small in-order owner FIFO.
module fft_frame_sched #(
  parameter int N       = 128,
  parameter int ADDR_W  = 7,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic              sink_inverse,
  input  logic              source_valid,
  input  logic              source_eop,
  output logic              src_owner,
  output logic              busy,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
  localparam logic [2:0]        OUT_MAX  = 3'(MAX_OUT);
  localparam logic [1:0]        PTR_LAST = 2'(MAX_OUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              last_owner_q, last_owner_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic [3:0]        owner_q;
  logic [1:0]        rd_ptr_q, wr_ptr_q;
  logic [2:0]        outst_q;
  logic              err_q;

  logic any_req, winner, start, accept, last_acc, pop_req, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign any_req  = req0 | req1;
  // On a tie the requester that did not own the previous frame wins.
  assign winner   = (req0 & req1) ? ~last_owner_q : req1;
  assign start    = (state_q == IDLE) & any_req & (outst_q < OUT_MAX);
  assign accept   = (state_q == STREAM) & sink_ready;
  assign last_acc = accept & (cnt_q == LAST);
  assign pop_req  = source_valid & source_eop;
  assign pop      = pop_req & (outst_q != 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start)    state_d = STREAM;
      STREAM: if (last_acc) state_d = IDLE;
    endcase
  end

  always_comb begin
    sink_valid   = (state_q == STREAM);
    sink_sop     = sink_valid & (cnt_q == '0);
    sink_eop     = sink_valid & (cnt_q == LAST);
    sink_inverse = sink_valid & ~sel_q;
    rd_addr      = sink_valid ? cnt_q : '0;
    rd_en        = sink_valid & sink_ready;
    gnt0         = gnt0_q;
    gnt1         = gnt1_q;
    sel          = sel_q;
    busy         = sink_valid | (outst_q != 3'd0);
    err          = err_q;
    src_owner    = (outst_q != 3'd0) & owner_q[rd_ptr_q];
  end

  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    if (start) begin
      cnt_d        = '0;
      sel_d        = winner;
      last_owner_d = winner;
      gnt0_d       = ~winner;
      gnt1_d       = winner;
    end else if (last_acc) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  // Owner FIFO: entry pushed on the final sink accept, popped on source eop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= '0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      outst_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      if (last_acc) begin
        owner_q[wr_ptr_q] <= sel_q;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (last_acc & ~pop)      outst_q <= outst_q + 3'd1;
      else if (pop & ~last_acc) outst_q <= outst_q - 3'd1;
      if (pop_req & (outst_q == 3'd0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: arbitration, streaming, backpressure, owner tagging, reset abort.
module tb_fft_frame_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       sink_ready = 1'b1;
  logic       source_valid = 1'b0, source_eop = 1'b0;
  logic       gnt0, gnt1, sel, rd_en, sink_valid, sink_sop, sink_eop, sink_inverse;
  logic       src_owner, busy, err;
  logic [6:0] rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  int f_cyc, f_rd, f_sop, f_eop, f_g0, f_g1, f_sel, f_inv, f_held, f_gap;

  wire [17:0] outs = {gnt0, gnt1, sel, rd_en, rd_addr, sink_valid, sink_sop, sink_eop,
                      sink_inverse, src_owner, busy, err};

  fft_frame_sched #(.N(128), .ADDR_W(7), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .sel(sel), .rd_en(rd_en), .rd_addr(rd_addr), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_inverse(sink_inverse), .source_valid(source_valid), .source_eop(source_eop),
    .src_owner(src_owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    source_valid = 1'b0;
    source_eop = 1'b0;
    sink_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic pop_one;
    source_valid = 1'b1;
    source_eop = 1'b1;
    tick();
    source_valid = 1'b0;
    source_eop = 1'b0;
  endtask

  // Waits for the next frame and streams it to completion, stalling sink_ready at stall_at.
  task automatic run_frame(input int stall_at, input int stall_len, input bit drop,
                           input bit pop_at_eop);
    int stalled;
    int t;
    stalled = 0; t = 0;
    f_cyc = 0; f_rd = 0; f_sop = -1; f_eop = -1; f_g0 = 0; f_g1 = 0; f_held = 1;
    while (!sink_valid && t < 50) begin
      tick();
      t++;
    end
    f_gap = t;
    if (!sink_valid) begin
      chk("frame_start_timeout", 32'd0, 32'd1);
      return;
    end
    while (sink_valid && f_cyc < 400) begin
      if (int'(rd_addr) == stall_at && stalled < stall_len) begin
        sink_ready = 1'b0;
        stalled++;
      end else begin
        sink_ready = 1'b1;
      end
      if (pop_at_eop && sink_eop && sink_ready) begin
        source_valid = 1'b1;
        source_eop = 1'b1;
      end
      if (drop && gnt0) req0 = 1'b0;
      if (drop && gnt1) req1 = 1'b0;
      #1;
      if (!sink_ready && (rd_en || int'(rd_addr) != stall_at || !sink_valid)) f_held = 0;
      f_cyc++;
      if (rd_en) f_rd++;
      if (sink_sop) f_sop = int'(rd_addr);
      if (sink_eop) f_eop = int'(rd_addr);
      f_g0 += int'(gnt0);
      f_g1 += int'(gnt1);
      f_sel = int'(sel);
      f_inv = int'(sink_inverse);
      tick();
      source_valid = 1'b0;
      source_eop = 1'b0;
    end
    sink_ready = 1'b1;
    if (sink_valid) chk("frame_end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;

    #12;
    chk("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_outs", 32'(outs), 32'd0);

    // Single TX frame
    req0 = 1'b1;
    run_frame(-1, 0, 1'b1, 1'b0);
    chk("t1_cycles", 32'(f_cyc), 32'd128);
    chk("t1_rd_en", 32'(f_rd), 32'd128);
    chk("t1_sop_addr", 32'(f_sop), 32'd0);
    chk("t1_eop_addr", 32'(f_eop), 32'd127);
    chk("t1_gnt0", 32'(f_g0), 32'd1);
    chk("t1_gnt1", 32'(f_g1), 32'd0);
    chk("t1_sel", 32'(f_sel), 32'd0);
    chk("t1_inverse", 32'(f_inv), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_src_owner", 32'(src_owner), 32'd0);
    pop_one();
    chk("t1_busy_after_pop", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // Both requesting: TX, RX, then stall at MAX_OUT
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("t2_f1_sel", 32'(f_sel), 32'd0);
    chk("t2_f1_gnt0", 32'(f_g0), 32'd1);
    chk("t2_f1_inverse", 32'(f_inv), 32'd1);
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("t2_f2_gap", 32'(f_gap), 32'd1);
    chk("t2_f2_sel", 32'(f_sel), 32'd1);
    chk("t2_f2_gnt1", 32'(f_g1), 32'd1);
    chk("t2_f2_inverse", 32'(f_inv), 32'd0);
    chk("t2_f2_cycles", 32'(f_cyc), 32'd128);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sink_valid || gnt0 || gnt1) bad++;
      tick();
    end
    chk("t2_stall_idle", 32'(bad), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_head_tx", 32'(src_owner), 32'd0);
    req1 = 1'b0;
    pop_one();
    chk("t2_head_rx", 32'(src_owner), 32'd1);

    // TX final accept coincides with RX source eop
    run_frame(-1, 0, 1'b1, 1'b1);
    chk("t4_f3_sel", 32'(f_sel), 32'd0);
    chk("t4_f3_gnt0", 32'(f_g0), 32'd1);
    chk("t4_f3_cycles", 32'(f_cyc), 32'd128);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_head_tx", 32'(src_owner), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    pop_one();
    chk("t4_busy_after_pop", 32'(busy), 32'd0);
    chk("t4_err_after_pop", 32'(err), 32'd0);

    // Backpressure at rd_addr 40 for 5 cycles
    req1 = 1'b1;
    run_frame(40, 5, 1'b1, 1'b0);
    chk("t3_cycles", 32'(f_cyc), 32'd133);
    chk("t3_rd_en", 32'(f_rd), 32'd128);
    chk("t3_held", 32'(f_held), 32'd1);
    chk("t3_sop_addr", 32'(f_sop), 32'd0);
    chk("t3_eop_addr", 32'(f_eop), 32'd127);
    chk("t3_sel", 32'(f_sel), 32'd1);
    chk("t3_inverse", 32'(f_inv), 32'd0);
    pop_one();
    chk("t3_busy_after_pop", 32'(busy), 32'd0);

    // Source eop with nothing outstanding
    pop_one();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(sink_valid), 32'd0);
    repeat (5) tick();
    chk("t5_err_sticky", 32'(err), 32'd1);
    req0 = 1'b1;
    run_frame(-1, 0, 1'b1, 1'b0);
    chk("t5_frame_cycles", 32'(f_cyc), 32'd128);
    chk("t5_frame_sel", 32'(f_sel), 32'd0);
    chk("t5_err_still", 32'(err), 32'd1);

    // Reset mid-frame
    do_reset();
    chk("t6_err_cleared", 32'(err), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    req0 = 1'b1;
    k = 0;
    while (!sink_valid && k < 50) begin
      tick();
      k++;
    end
    req0 = 1'b0;
    k = 0;
    while (rd_addr != 7'd64 && k < 200) begin
      tick();
      k++;
    end
    chk("t6_reached_64", 32'(rd_addr), 32'd64);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_outs", 32'(outs), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("t6_no_entry_busy", 32'(busy), 32'd0);
    chk("t6_no_entry_owner", 32'(src_owner), 32'd0);
    req1 = 1'b1;
    run_frame(-1, 0, 1'b1, 1'b0);
    chk("t6_sop_addr", 32'(f_sop), 32'd0);
    chk("t6_cycles", 32'(f_cyc), 32'd128);
    chk("t6_sel", 32'(f_sel), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_src_owner", 32'(src_owner), 32'd1);
    pop_one();
    chk("t6_busy_after_pop", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
